apb_slave_regfile: RTL and testbench

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_slave_regfile.sv | 125 ++++++++++++
 tb/tb_apb_slave_regfile.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave register file.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [15:0] ID_VALUE  = 16'hA5B0;
    localparam int          DEF_WIDTH = 16;

endpackage

// File: rtl/apb_slave_regfile.sv
// APB slave with a small register file, register 0 a read-only ID, optional wait states.
// Optional APB_SLV_PSLVERR_EN adds a registered pslverr output for invalid accesses.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             pselect,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [WIDTH-1:0] paddr,
    input  logic [WIDTH-1:0] pwdata,
    output logic             pready,
    output logic [WIDTH-1:0] prdata
`ifdef APB_SLV_PSLVERR_EN
    ,
    output logic             pslverr
`endif
);

    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t           state;
    logic [3:0]       cnt;
    logic             wr_q;
    logic             valid_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] regs [1:NUM_REGS-1];

    logic             setup, access, enter_ready, hold_ready;
    logic             cur_wr, cur_valid;
    logic [IDXW-1:0]  cur_idx;
    logic [WIDTH-1:0] rd_data;

    // In IDLE the transfer is decoded straight from the bus so a zero-wait
    // read can load prdata on the setup edge; afterwards the latched copy is used.
    always_comb begin
        setup       = pselect && !penable;
        access      = pselect && penable;
        cur_wr      = (state == ST_IDLE) ? pwrite : wr_q;
        cur_valid   = (state == ST_IDLE) ? (paddr < WIDTH'(NUM_REGS)) : valid_q;
        cur_idx     = (state == ST_IDLE) ? paddr[IDXW-1:0] : idx_q;
        enter_ready = (state == ST_IDLE && setup && WAIT_STATES == 0) ||
                      (state == ST_WAIT && access && cnt == 4'd1);
        hold_ready  = (state == ST_READY) && setup;
        rd_data     = '0;
        if (!cur_wr && cur_valid) begin
            if (cur_idx == '0)
                rd_data = WIDTH'(ID_VALUE);
            for (int i = 1; i < NUM_REGS; i++)
                if (cur_idx == IDXW'(i))
                    rd_data = regs[i];
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        wr_q    <= pwrite;
                        valid_q <= cur_valid;
                        idx_q   <= paddr[IDXW-1:0];
                        wdata_q <= pwdata;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= (WAIT_STATES == 0) ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!pselect) begin
                        state <= ST_IDLE;
                    end else if (penable) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1)
                            state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (!pselect) begin
                        state <= ST_IDLE;
                    end else if (penable) begin
                        if (wr_q && valid_q)
                            for (int i = 1; i < NUM_REGS; i++)
                                if (idx_q == IDXW'(i))
                                    regs[i] <= wdata_q;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            pready <= enter_ready || hold_ready;
            prdata <= enter_ready ? rd_data : (hold_ready ? prdata : '0);
        end
    end

`ifdef APB_SLV_PSLVERR_EN
    logic cur_err;

    assign cur_err = !cur_valid || (cur_wr && cur_idx == '0);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset)
            pslverr <= 1'b0;
        else
            pslverr <= enter_ready ? cur_err : (hold_ready ? pslverr : 1'b0);
    end
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized bench for apb_slave_regfile: three instances (0, 2, 3 wait states) against an array model.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel [3];
    logic        pen  [3];
    logic        pwr  [3];
    logic [15:0] padr [3];
    logic [15:0] pwd  [3];
    logic        rdy  [3];
    logic [15:0] prd  [3];
`ifdef APB_SLV_PSLVERR_EN
    logic        err  [3];
`endif

    logic [15:0] model [3][8];
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_slave_regfile #(
            .WIDTH(16), .NUM_REGS(8),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .pclk(clk), .preset(rst),
            .pselect(psel[g]), .penable(pen[g]), .pwrite(pwr[g]),
            .paddr(padr[g]), .pwdata(pwd[g]),
            .pready(rdy[g]), .prdata(prd[g])
`ifdef APB_SLV_PSLVERR_EN
            , .pslverr(err[g])
`endif
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic release_all();
        for (int i = 0; i < 3; i++) begin
            psel[i] = 1'b0;
            pen[i]  = 1'b0;
        end
    endtask

    task automatic check_idle(input int d);
        chk("idle_pready", 32'(rdy[d]), 32'd0);
        chk("idle_prdata", 32'(prd[d]), 32'd0);
`ifdef APB_SLV_PSLVERR_EN
        chk("idle_pslverr", 32'(err[d]), 32'd0);
`endif
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 8; r++)
                model[d][r] = 16'h0000;
    endtask

    // One APB transfer; abort_at = k drops pselect during the k-th access cycle (-1: none).
    task automatic xfer(input int d, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input int abort_at);
        int          ws;
        bit          valid;
        logic [15:0] exp_rd;
        ws    = ws_of(d);
        valid = (a < 16'd8);
        @(negedge clk);
        check_idle(d);
        if (rst) rst = 1'b0;
        release_all();
        psel[d] = 1'b1;
        pen[d]  = 1'b0;
        pwr[d]  = wr;
        padr[d] = a;
        pwd[d]  = wr ? wd : 16'($urandom);
        if (wr || !valid)   exp_rd = 16'h0000;
        else if (a == 16'd0) exp_rd = 16'hA5B0;
        else                exp_rd = model[d][a[2:0]];
        @(posedge clk);
        for (int k = 0; k <= ws; k++) begin
            @(negedge clk);
            pen[d] = 1'b1;
            chk("pready", 32'(rdy[d]), 32'(k == ws));
            if (k == ws) begin
                chk("prdata", 32'(prd[d]), 32'(exp_rd));
`ifdef APB_SLV_PSLVERR_EN
                chk("pslverr", 32'(err[d]), 32'(!valid || (wr && a == 16'd0)));
`endif
            end else begin
                chk("prdata_wait", 32'(prd[d]), 32'd0);
            end
            if (k == abort_at) begin
                psel[d] = 1'b0;
                pen[d]  = 1'b0;
                @(posedge clk);
                return;
            end
            @(posedge clk);
        end
        if (wr && valid && a != 16'd0)
            model[d][a[2:0]] = wd;
    endtask

    task automatic idle(input int n, input bit viol);
        repeat (n) begin
            @(negedge clk);
            release_all();
            if (viol) begin
                int d;
                d = $urandom_range(0, 2);
                psel[d] = 1'b1;
                pen[d]  = 1'b1;
                padr[d] = 16'($urandom_range(1, 7));
                pwr[d]  = 1'b1;
                pwd[d]  = 16'($urandom);
            end
            @(posedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        release_all();
        for (int i = 0; i < 3; i++) begin
            pwr[i] = 1'b0; padr[i] = '0; pwd[i] = '0;
        end
        clear_model();
        #1;
        for (int d = 0; d < 3; d++) check_idle(d);
        repeat (2) @(posedge clk);

        // first transfer released in the same half-cycle as reset deassertion
        xfer(0, 1'b1, 16'd3, 16'h1234, -1);
        xfer(0, 1'b0, 16'd3, 16'h0000, -1);
        xfer(1, 1'b0, 16'd0, 16'h0000, -1);
        xfer(0, 1'b1, 16'd0, 16'hFFFF, -1);
        xfer(0, 1'b1, 16'd9, 16'hFFFF, -1);
        xfer(0, 1'b0, 16'd0, 16'h0000, -1);
        xfer(0, 1'b0, 16'd9, 16'h0000, -1);
        xfer(2, 1'b1, 16'd5, 16'h00AA, 1);
        xfer(2, 1'b0, 16'd5, 16'h0000, -1);
        xfer(0, 1'b1, 16'd2, 16'h5555, -1);
        xfer(0, 1'b0, 16'd2, 16'h0000, -1);

        // reset during the access phase of a write
        @(negedge clk);
        release_all();
        psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; padr[0] = 16'd2; pwd[0] = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        pen[0] = 1'b1;
        chk("rst_pre_pready", 32'(rdy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_pready", 32'(rdy[0]), 32'd0);
        chk("rst_prdata", 32'(prd[0]), 32'd0);
        release_all();
        clear_model();
        xfer(0, 1'b0, 16'd2, 16'h0000, -1);

        xfer(0, 1'b1, 16'd1, 16'h0F0F, -1);
        xfer(0, 1'b0, 16'd1, 16'h0000, -1);

        for (int n = 0; n < 120; n++) begin
            int          d;
            bit          wr;
            logic [15:0] a;
            int          ab;
            d  = $urandom_range(0, 2);
            wr = 1'($urandom);
            if ($urandom_range(0, 4) == 0) a = 16'h8000 | 16'($urandom_range(0, 7));
            else                           a = 16'($urandom_range(0, 9));
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, ws_of(d)) : -1;
            xfer(d, wr, a, 16'($urandom), ab);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'($urandom));
        end

        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 8; r++)
                xfer(d, 1'b0, 16'(r), 16'h0000, -1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
